control_fsm: RTL

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/ctrl_pkg.sv | 44 ++++
 rtl/ctrl_wait_cnt.sv | 25 ++
 rtl/control_fsm.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle controller and the downstream ALU control decoder:
// state codes, opcode field values and ALUOp encodings.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_SW  = 3'b001;
    localparam logic [2:0] OP_R   = 3'b010;
    localparam logic [2:0] OP_I   = 3'b011;
    localparam logic [2:0] OP_BR  = 3'b100;
    localparam logic [2:0] OP_JAL = 3'b101;

    localparam logic [1:0] S_T = 2'b00;
    localparam logic [1:0] B_T = 2'b01;
    localparam logic [1:0] R_T = 2'b10;
    localparam logic [1:0] I_T = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_TWO = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;

endpackage

// File: rtl/ctrl_wait_cnt.sv
// Memory wait counter: counts up to limit without wrapping; done flags the last wait cycle.
module ctrl_wait_cnt (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic [1:0] limit,
    output logic       done
);

    logic [1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 2'd0;
        end else if (clear) begin
            cnt <= 2'd0;
        end else if (enable && (cnt < limit)) begin
            cnt <= cnt + 2'd1;
        end
    end

    assign done = (cnt == limit);

endmodule

// File: rtl/control_fsm.sv
// Moore control FSM for a multicycle datapath with MEM_LAT-cycle memory accesses.
// Build option: CTRL_ILLEGAL_TRAP_EN traps illegal opcodes in HALT; otherwise they act as NOPs.
//
// state    | meaning
// FETCH    | read instruction, PC += 2 on last wait cycle
// DECODE   | read registers, compute branch/jump target
// MEMADR   | compute load/store address
// MEMREAD  | hold data address for MEM_LAT cycles
// MEMWB    | write load data to register file
// MEMWRITE | single-cycle store strobe
// EXEC_R   | register-register ALU op
// EXEC_I   | register-immediate ALU op
// ALUWB    | write ALU result to register file
// BRANCH   | compare and conditionally update PC
// JAL      | jump, link address computed for ALUWB
// HALT     | illegal-opcode trap, left only by reset
module control_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       Branch,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUOp,
    output logic [3:0] state,
    output logic       halted
);

    localparam logic [1:0] WAIT_LIMIT = 2'(MEM_LAT - 1);

    state_t state_q, state_d;
    logic   cnt_clear, cnt_en, cnt_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Clearing on every transition guarantees cnt==0 on entry to any state.
    assign cnt_clear = (state_d != state_q);
    assign cnt_en    = (state_q == S_FETCH) || (state_q == S_MEMREAD);

    ctrl_wait_cnt u_wait_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .limit  (WAIT_LIMIT),
        .done   (cnt_done)
    );

    always_comb begin
        state_d   = state_q;
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        Branch    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_REG;
        ResultSrc = RES_ALUOUT;
        ALUOp     = S_T;

        case (state_q)
            S_FETCH: begin
                ALUSrcB   = SRCB_TWO;
                ResultSrc = RES_ALURES;
                if (cnt_done) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_BR:        state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:      state_d = S_HALT;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
                // opcode is re-sampled here; anything but LW/SW abandons the access
                if (opcode == OP_LW) begin
                    state_d = S_MEMREAD;
                end else if (opcode == OP_SW) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (cnt_done) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ResultSrc = RES_MEMDATA;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXEC_R: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_REG;
                ALUOp   = R_T;
                state_d = S_ALUWB;
            end
            S_EXEC_I: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
                ALUOp   = I_T;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_REG;
                ALUOp   = B_T;
                Branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_TWO;
                PCWrite = 1'b1;
                state_d = S_ALUWB;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_HALT: begin
                state_d = S_HALT;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // FETCH with MEM_LAT=1 would otherwise strobe IRWrite/PCWrite while reset is held.
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            Branch   = 1'b0;
        end
    end

    assign state = state_q;

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign halted = (state_q == S_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule
